// File: rtl/my_type_pkg.sv
// Shared word type and width helper for the typed channel FIFO family.
package my_type_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] my_type_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/typed_fifo_ch.sv
// One channel of elastic buffering: DEPTH-entry FIFO with valid/ready on both
// sides, occupancy count and synchronous flush.
module typed_fifo_ch
    import my_type_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = clog2_cnt(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  my_type_t         in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output my_type_t         out_data,
    output logic [CNT_W-1:0] count
);

    my_type_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths return to 0 after DEPTH-1.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Storage is left untouched; only the bookkeeping is cleared.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (!push && pop) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/typed_chan_fifo.sv
// NUM_CH independent typed FIFO channels; the top only slices packed port arrays.
module typed_chan_fifo
    import my_type_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    localparam int CNT_W = clog2_cnt(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic     [NUM_CH-1:0]         flush,
    input  logic     [NUM_CH-1:0]         in_valid,
    output logic     [NUM_CH-1:0]         in_ready,
    input  my_type_t [NUM_CH-1:0]         in_data,
    output logic     [NUM_CH-1:0]         out_valid,
    input  logic     [NUM_CH-1:0]         out_ready,
    output my_type_t [NUM_CH-1:0]         out_data,
    output logic     [NUM_CH-1:0][CNT_W-1:0] count
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        typed_fifo_ch #(.DEPTH(DEPTH)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[c]),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .in_data   (in_data[c]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .out_data  (out_data[c]),
            .count     (count[c])
        );
    end

endmodule

// File: tb/tb_typed_chan_fifo.sv
// Bench for typed_chan_fifo: directed scenarios plus random traffic against
// queue-based reference models (DEPTH=4 two-channel and DEPTH=3 one-channel).
module tb_typed_chan_fifo;
    import my_type_pkg::*;

    localparam int NCH = 2;
    localparam int D   = 4;
    localparam int CW  = clog2_cnt(D);
    localparam int D3  = 3;
    localparam int CW3 = clog2_cnt(D3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic     [NCH-1:0]         flush, in_valid, in_ready, out_valid, out_ready;
    my_type_t [NCH-1:0]         in_data, out_data;
    logic     [NCH-1:0][CW-1:0] count;

    logic     [0:0]          fl3, iv3, ir3, ov3, or3;
    my_type_t [0:0]          id3, od3;
    logic     [0:0][CW3-1:0] cnt3;

    int tests = 0;
    int fails = 0;

    my_type_t q  [NCH][$];
    my_type_t q3 [$];

    typed_chan_fifo #(.NUM_CH(NCH), .DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    typed_chan_fifo #(.NUM_CH(1), .DEPTH(D3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(fl3), .in_valid(iv3),
        .in_ready(ir3), .in_data(id3), .out_valid(ov3),
        .out_ready(or3), .out_data(od3), .count(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_main();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count%0d", c), 32'(count[c]), 32'(q[c].size()));
            chk($sformatf("out_valid%0d", c), 32'(out_valid[c]), 32'(q[c].size() != 0));
            chk($sformatf("in_ready%0d", c), 32'(in_ready[c]), 32'(q[c].size() != D));
            if (q[c].size() != 0)
                chk($sformatf("out_data%0d", c), out_data[c], q[c][0]);
        end
    endtask

    task automatic check_d3();
        chk("d3_count", 32'(cnt3[0]), 32'(q3.size()));
        chk("d3_out_valid", 32'(ov3[0]), 32'(q3.size() != 0));
        chk("d3_in_ready", 32'(ir3[0]), 32'(q3.size() != D3));
        if (q3.size() != 0) chk("d3_out_data", od3[0], q3[0]);
    endtask

    // One clock of the main DUT: drive, let the edge happen, update model, check.
    task automatic step(input logic [1:0] iv, input my_type_t d0, input my_type_t d1,
                        input logic [1:0] ordy, input logic [1:0] fl);
        logic     pu [NCH];
        logic     po [NCH];
        my_type_t dd [NCH];
        dd[0] = d0;
        dd[1] = d1;
        in_valid = iv; in_data[0] = d0; in_data[1] = d1; out_ready = ordy; flush = fl;
        for (int c = 0; c < NCH; c++) begin
            pu[c] = iv[c] && (q[c].size() != D);
            po[c] = ordy[c] && (q[c].size() != 0);
        end
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) begin
            if (fl[c]) q[c].delete();
            else begin
                if (po[c]) void'(q[c].pop_front());
                if (pu[c]) q[c].push_back(dd[c]);
            end
        end
        check_main();
    endtask

    task automatic step3(input logic iv, input my_type_t d, input logic ordy, input logic fl);
        logic pu, po;
        iv3[0] = iv; id3[0] = d; or3[0] = ordy; fl3[0] = fl;
        pu = iv && (q3.size() != D3);
        po = ordy && (q3.size() != 0);
        @(posedge clk); #1;
        if (fl) q3.delete();
        else begin
            if (po) void'(q3.pop_front());
            if (pu) q3.push_back(d);
        end
        check_d3();
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_data = '0; out_ready = '0; flush = '0;
        iv3 = '0; id3 = '0; or3 = '0; fl3 = '0;
    endtask

    task automatic check_reset_values(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk({tag, "_count"}, 32'(count[c]), 32'd0);
            chk({tag, "_out_valid"}, 32'(out_valid[c]), 32'd0);
            chk({tag, "_in_ready"}, 32'(in_ready[c]), 32'd1);
            chk({tag, "_out_data"}, out_data[c], 32'd0);
        end
        chk({tag, "_d3_count"}, 32'(cnt3[0]), 32'd0);
        chk({tag, "_d3_out_data"}, od3[0], 32'd0);
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset");

        // Fill ch0 to full, then a 5th offer must be ignored.
        for (int k = 1; k <= 4; k++) begin
            step(2'b01, 32'hDEAD_0000 + k, '0, 2'b00, 2'b00);
            chk("fill_count", 32'(count[0]), 32'(k));
        end
        chk("full_in_ready", 32'(in_ready[0]), 32'd0);
        step(2'b01, 32'hDEAD_0005, '0, 2'b00, 2'b00);
        chk("fifth_ignored", 32'(count[0]), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", out_data[0], 32'hDEAD_0000 + k);
            step(2'b00, '0, '0, 2'b01, 2'b00);
        end
        chk("drained", 32'(out_valid[0]), 32'd0);

        // Simultaneous push/pop at count 2.
        step(2'b01, 32'hA000_0001, '0, 2'b00, 2'b00);
        step(2'b01, 32'hA000_0002, '0, 2'b00, 2'b00);
        for (int k = 3; k <= 8; k++) begin
            step(2'b01, 32'hA000_0000 + k, '0, 2'b01, 2'b00);
            chk("pushpop_count", 32'(count[0]), 32'd2);
        end
        repeat (2) step(2'b00, '0, '0, 2'b01, 2'b00);

        // Flush ch1 at count 3 with a concurrent push; ch0 keeps streaming.
        for (int k = 0; k < 3; k++)
            step(2'b11, 32'hB000_0000 + k, 32'hC000_0000 + k, 2'b01, 2'b00);
        chk("pre_flush_count1", 32'(count[1]), 32'd3);
        step(2'b11, 32'hB000_0010, 32'hCAFE_0000, 2'b01, 2'b10);
        chk("flush_count1", 32'(count[1]), 32'd0);
        chk("flush_valid1", 32'(out_valid[1]), 32'd0);
        step(2'b10, '0, 32'hC000_0100, 2'b11, 2'b00);
        chk("post_flush_data1", out_data[1], 32'hC000_0100);
        repeat (4) step(2'b00, '0, '0, 2'b11, 2'b00);

        // No bypass: a word pushed into an empty channel appears one cycle later.
        chk("lat_empty", 32'(out_valid[0]), 32'd0);
        step(2'b01, 32'h1234_5678, '0, 2'b01, 2'b00);
        chk("lat_n1_valid", 32'(out_valid[0]), 32'd1);
        chk("lat_n1_data", out_data[0], 32'h1234_5678);
        step(2'b00, '0, '0, 2'b01, 2'b00);
        chk("lat_n2_valid", 32'(out_valid[0]), 32'd0);

        // DEPTH=3: 10 words streamed through to exercise 2->0 pointer wrap.
        step3(1'b1, 32'hD300_0000, 1'b0, 1'b0);
        step3(1'b1, 32'hD300_0001, 1'b0, 1'b0);
        for (int k = 2; k < 10; k++) begin
            chk("d3_wrap_head", od3[0], 32'hD300_0000 + k - 2);
            step3(1'b1, 32'hD300_0000 + k, 1'b1, 1'b0);
        end
        for (int k = 8; k < 10; k++) begin
            chk("d3_wrap_tail", od3[0], 32'hD300_0000 + k);
            step3(1'b0, '0, 1'b1, 1'b0);
        end
        chk("d3_wrap_empty", 32'(ov3[0]), 32'd0);

        // Random traffic on both DUTs (main model checked each cycle).
        for (int n = 0; n < 300; n++) begin
            logic [1:0] fl;
            fl[0] = ($urandom_range(0, 15) == 0);
            fl[1] = ($urandom_range(0, 15) == 0);
            iv3[0] = 1'($urandom); id3[0] = $urandom; or3[0] = 1'($urandom);
            fl3[0] = ($urandom_range(0, 15) == 0);
            begin
                logic pu3, po3;
                logic fl3_s;
                my_type_t d3;
                pu3 = iv3[0] && (q3.size() != D3);
                po3 = or3[0] && (q3.size() != 0);
                fl3_s = fl3[0];
                d3 = id3[0];
                step(2'($urandom), $urandom, $urandom, 2'($urandom), fl);
                if (fl3_s) q3.delete();
                else begin
                    if (po3) void'(q3.pop_front());
                    if (pu3) q3.push_back(d3);
                end
                check_d3();
            end
        end

        // Mid-stream async reset with data held in both channels.
        idle_inputs();
        step(2'b11, 32'hE000_0001, 32'hE100_0001, 2'b00, 2'b00);
        step(2'b11, 32'hE000_0002, 32'hE100_0002, 2'b00, 2'b00);
        step3(1'b1, 32'hE300_0001, 1'b0, 1'b0);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        for (int c = 0; c < NCH; c++) q[c].delete();
        q3.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");
        step(2'b01, 32'hF000_0001, '0, 2'b00, 2'b00);
        step(2'b00, '0, '0, 2'b11, 2'b00);
        step(2'b00, '0, '0, 2'b11, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
